conv_mac_array: RTL and testbench
=================================

# conv_mac_array

Streaming, pipelined multiply-accumulate array for the convolution datapath. Each accepted input pixel is multiplied by all K*K weights of its channel's kernel. The products are accumulated across CH consecutive channel beats, and one K*K vector of partial sums is emitted per group. The block extends the single-pixel combinational multiplier stage with:

- a writable per-channel weight bank,
- signed/unsigned mode,
- channel accumulation,
- valid/ready flow control.

It sits between the pixel fetch stream and the output-tile adder tree.

## Interface

Parameters:

- K, 3: kernel side; K*K lanes.
- ILEN, 8: pixel and weight width.
- OLEN, 16: product width; must be ≥ 2*ILEN.
- CH, 4: channels accumulated per group; ≥ 1.
- ALEN, 18: accumulator and output width; must be ≥ OLEN.

Ports:

- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- signed_mode, input, 1: 1 = two's-complement operands, 0 = unsigned.
- wt_we, input, 1: weight write request.
- wt_ready, output, 1: weight bank writable this cycle.
- wt_addr, input, $clog2(CH*K*K): weight index, computed as channel*K*K + lane.
- wt_data, input, ILEN: weight value.
- in_valid, input, 1: pixel beat valid.
- in_ready, output, 1: pixel beat accepted when in_valid && in_ready.
- in_pix, input, ILEN: pixel value.
- out_valid, output, 1: out_sum holds a completed group.
- out_ready, input, 1: consumer accepts out_sum.
- out_sum, output, ALEN x [0:K*K-1]: per-lane accumulated sums, as an unpacked array.
- ch_idx, output, $clog2(CH) (min 1): channel index the next accepted beat will use.

## Operation

**Weight bank.** CH*K*K registers of ILEN bits.

- A write happens when wt_we && wt_ready.
- wt_ready = !rst && ch_idx==0 && !p_valid, i.e. no group is in flight and the product stage is empty.
- wt_we while wt_ready=0 is ignored and leaves no side effect.
- wt_addr ≥ CH*K*K is ignored.

**Advance enable.** adv = !(out_valid && !out_ready). in_ready = adv && !rst.

**Stage 1 (product).** On an accept:

- p[i] <= ext(in_pix) * ext(W[ch_idx*K*K + i]) for every lane i.
- p_valid <= 1. p_last <= (ch_idx==CH-1).
- ch_idx increments and wraps from CH-1 to 0.
- When adv=1 and there is no accept, p_valid <= 0. When adv=0, stage 1 holds.
- The first beat of a group (ch_idx==0) latches signed_mode into grp_signed. Changes to signed_mode mid-group are ignored until the next group.

**Extension rules.** grp_signed=1 uses sign extension; grp_signed=0 uses zero extension. Product is OLEN bits and is extended to ALEN with the same rule.

**Stage 2 (accumulate).** When adv && p_valid:

- sum = (p_first ? 0 : acc) + p, per lane, modulo 2^ALEN. No saturation.
- If p_last: out_sum <= sum, out_valid <= 1, and acc is cleared.
- Otherwise acc <= sum.
- p_first is tracked alongside p_valid.

**Output.** out_valid clears on out_ready when no new group completes in the same cycle. A new group completing in the same cycle as out_ready overwrites out_sum and keeps out_valid=1.

**Reset.** Clears:

- all weights to 0,
- acc, out_sum, p, p_valid, grp_signed,
- ch_idx to 0,
- out_valid to 0.

in_ready=0 and wt_ready=0 while rst=1. A partially accumulated group is discarded.

## Timing

- Reset values: out_valid=0, out_sum=0, ch_idx=0. in_ready and wt_ready are 0 during rst and 1 on the first cycle after it.
- Latency: if the last beat of a group is accepted at edge E, out_valid=1 after edge E+1 (2-edge pipeline).
- Throughput: one beat per cycle while out_ready=1 or out_valid=0.
- Stall: while out_valid && !out_ready, in_ready=0 and both stages hold their state.
- A weight write at edge E is visible to a beat accepted at edge E+1.
- CH=1 case: every beat is both first and last, and one group completes per beat.

## Test plan

- **Unsigned accumulation.** K=3, CH=4; load W[c][i]=i+1 for every channel; signed_mode=0; stream pixels 1,2,3,4 -> out_sum[i]=10*(i+1), i.e. {10,20,...,90}, with out_valid exactly 2 edges after the 4th accept.
- **Signed vs unsigned.** All weights 0x02; 4 beats of pixel 0xFF. signed_mode=1 -> every lane = 18'h3FFF8 (-8). signed_mode=0 -> every lane = 18'h007F8 (2040).
- **Backpressure.** Hold out_ready=0 after group 1 completes and stream group 2 -> in_ready=0 while out_valid=1; out_sum stays at the group-1 value. Release out_ready -> group 2 resumes without loss and its result is correct.
- **Weight-write gating.** wt_we mid-group (ch_idx=2) -> wt_ready=0 and the weight is unchanged. The same write after the group completes -> the weight is updated and used by the next group.
- **Reset mid-group.** Accept 2 of 4 beats, pulse rst for 1 cycle -> out_valid=0, ch_idx=0, weights=0. Reload weights=1 and stream 5,5,5,5 -> every lane = 20, with no contribution from the pre-reset beats.
- **Mode change mid-group.** Toggle signed_mode after the first beat of a group (0xFF pixels, weights 0x02, group started unsigned) -> result 2040 per lane, confirming the mode latched at group start.

Source files
------------

// File: rtl/conv_mac_if.sv
// Handshake and data bundle between the pixel fetch stream, the weight loader
// and the conv_mac_array multiply-accumulate block.
interface conv_mac_if #(
  parameter int K    = 3,
  parameter int ILEN = 8,
  parameter int CH   = 4,
  parameter int ALEN = 18
);
  localparam int N  = K * K;
  localparam int NW = CH * N;
  localparam int AW = (NW > 1) ? $clog2(NW) : 1;
  localparam int CW = (CH > 1) ? $clog2(CH) : 1;

  logic            signed_mode;
  logic            wt_we;
  logic            wt_ready;
  logic [AW-1:0]   wt_addr;
  logic [ILEN-1:0] wt_data;
  logic            in_valid;
  logic            in_ready;
  logic [ILEN-1:0] in_pix;
  logic            out_valid;
  logic            out_ready;
  logic [ALEN-1:0] out_sum [N];
  logic [CW-1:0]   ch_idx;

  modport master (
    output signed_mode, wt_we, wt_addr, wt_data, in_valid, in_pix, out_ready,
    input  wt_ready, in_ready, out_valid, out_sum, ch_idx
  );

  modport slave (
    input  signed_mode, wt_we, wt_addr, wt_data, in_valid, in_pix, out_ready,
    output wt_ready, in_ready, out_valid, out_sum, ch_idx
  );
endinterface

// File: rtl/conv_mac_array.sv
// Streaming K*K multiply-accumulate array: per-channel weight bank, a product stage
// and a channel accumulator that emits one vector of partial sums per CH-beat group.
module conv_mac_array #(
  parameter int K    = 3,
  parameter int ILEN = 8,
  parameter int OLEN = 16,
  parameter int CH   = 4,
  parameter int ALEN = 18
) (
  input logic       clk,
  input logic       rst,
  conv_mac_if.slave bus
);
  localparam int N  = K * K;
  localparam int NW = CH * N;
  localparam int AW = (NW > 1) ? $clog2(NW) : 1;
  localparam int CW = (CH > 1) ? $clog2(CH) : 1;
  localparam logic [CW-1:0] CH_LAST = CW'(CH - 1);

  function automatic logic [OLEN-1:0] ext_o(input logic [ILEN-1:0] v, input logic s);
    logic [OLEN-1:0] r;
    if (s) r = OLEN'($signed(v));
    else   r = OLEN'(v);
    return r;
  endfunction

  function automatic logic [ALEN-1:0] ext_a(input logic [OLEN-1:0] v, input logic s);
    logic [ALEN-1:0] r;
    if (s) r = ALEN'($signed(v));
    else   r = ALEN'(v);
    return r;
  endfunction

  logic [ILEN-1:0] wt [NW];
  logic [CW-1:0]   ch_idx;
  logic            grp_signed;
  logic [OLEN-1:0] p [N];
  logic            p_valid;
  logic            p_first;
  logic            p_last;
  logic            p_signed;
  logic [ALEN-1:0] acc [N];
  logic [ALEN-1:0] out_sum [N];
  logic            out_valid;

  logic            adv;
  logic            accept;
  logic            wt_wr;
  logic            grp_start;
  logic            cur_signed;
  logic [AW-1:0]   base;
  logic [OLEN-1:0] p_next [N];
  logic [ALEN-1:0] sum [N];

  assign adv          = !(out_valid && !bus.out_ready);
  assign grp_start    = (ch_idx == '0);
  assign bus.in_ready = adv && !rst;
  assign bus.wt_ready = !rst && grp_start && !p_valid;
  assign accept       = bus.in_valid && bus.in_ready;
  assign wt_wr        = bus.wt_we && bus.wt_ready && (int'(bus.wt_addr) < NW);

  // The first beat of a group follows the live mode pin; later beats use the latched mode.
  assign cur_signed = grp_start ? bus.signed_mode : grp_signed;
  assign base       = AW'(int'(ch_idx) * N);

  assign bus.out_valid = out_valid;
  assign bus.out_sum   = out_sum;
  assign bus.ch_idx    = ch_idx;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      p_next[i] = ext_o(bus.in_pix, cur_signed) * ext_o(wt[base + AW'(i)], cur_signed);
      sum[i]    = (p_first ? '0 : acc[i]) + ext_a(p[i], p_signed);
    end
  end

  // Both pipeline stages and the output register freeze together while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NW; i++) wt[i] <= '0;
      for (int i = 0; i < N; i++) begin
        p[i]       <= '0;
        acc[i]     <= '0;
        out_sum[i] <= '0;
      end
      ch_idx     <= '0;
      grp_signed <= 1'b0;
      p_valid    <= 1'b0;
      p_first    <= 1'b0;
      p_last     <= 1'b0;
      p_signed   <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      if (wt_wr) wt[bus.wt_addr] <= bus.wt_data;
      if (adv) begin
        p_valid <= accept;
        if (accept) begin
          for (int i = 0; i < N; i++) p[i] <= p_next[i];
          p_first  <= grp_start;
          p_last   <= (ch_idx == CH_LAST);
          p_signed <= cur_signed;
          if (grp_start) grp_signed <= bus.signed_mode;
          ch_idx   <= (ch_idx == CH_LAST) ? '0 : ch_idx + 1'b1;
        end
        if (p_valid && p_last) begin
          for (int i = 0; i < N; i++) begin
            out_sum[i] <= sum[i];
            acc[i]     <= '0;
          end
          out_valid <= 1'b1;
        end else begin
          if (p_valid) begin
            for (int i = 0; i < N; i++) acc[i] <= sum[i];
          end
          if (bus.out_ready) out_valid <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_conv_mac_array.sv
// Directed and randomised bench for conv_mac_array: an arithmetic reference model
// fills a scoreboard queue that an independent output monitor drains.
module tb_conv_mac_array;
  localparam int K    = 3;
  localparam int ILEN = 8;
  localparam int OLEN = 16;
  localparam int CH   = 4;
  localparam int ALEN = 18;
  localparam int N    = K * K;
  localparam int NW   = CH * N;
  localparam int AW   = $clog2(NW);

  typedef logic [N-1:0][ALEN-1:0] vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  conv_mac_if #(.K(K), .ILEN(ILEN), .CH(CH), .ALEN(ALEN)) bus ();

  conv_mac_array #(.K(K), .ILEN(ILEN), .OLEN(OLEN), .CH(CH), .ALEN(ALEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  vec_t        exp_q [$];
  int unsigned mw [NW];
  longint      macc [N];
  int          mch = 0;
  bit          mgs = 1'b0;
  bit          rand_done = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic longint opv(input int unsigned v, input bit s);
    if (s && v >= 128) return longint'(v) - 256;
    return longint'(v);
  endfunction

  // Reference: integer sum over the group of pixel*weight, reduced modulo 2^ALEN.
  task automatic modelAccept(input int unsigned pix, input bit smode);
    vec_t e;
    if (mch == 0) begin
      mgs = smode;
      for (int i = 0; i < N; i++) macc[i] = 0;
    end
    for (int i = 0; i < N; i++) macc[i] += opv(pix, mgs) * opv(mw[mch * N + i], mgs);
    mch++;
    if (mch == CH) begin
      for (int i = 0; i < N; i++) e[i] = ALEN'(macc[i]);
      exp_q.push_back(e);
      mch = 0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input int unsigned pix, input bit smode);
    bit done = 1'b0;
    bus.in_pix      = ILEN'(pix);
    bus.signed_mode = smode;
    bus.in_valid    = 1'b1;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        checkOutput("ch_idx", 64'(bus.ch_idx), 64'(mch));
        modelAccept(pix, smode);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!done) begin
      total++;
      bad++;
      $display("[TB] FAIL accept_timeout: got in_ready=0 expected a beat accept");
    end
  endtask

  task automatic writeWeight(input int unsigned addr, input int unsigned data);
    bit done = 1'b0;
    bus.wt_we   = 1'b1;
    bus.wt_addr = AW'(addr);
    bus.wt_data = ILEN'(data);
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      if (bus.wt_ready) begin
        if (addr < NW) mw[addr] = data;
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    bus.wt_we = 1'b0;
    if (!done) begin
      total++;
      bad++;
      $display("[TB] FAIL wt_write_timeout: got wt_ready=0 expected a weight write");
    end
  endtask

  task automatic loadWeights(input int kind, input int unsigned val);
    int unsigned d;
    for (int a = 0; a < NW; a++) begin
      if (kind == 0)      d = (a % N) + 1;
      else if (kind == 1) d = val;
      else                d = $urandom_range(0, 255);
      writeWeight(a, d);
    end
  endtask

  task automatic drain();
    int c = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && c < 200) begin
      @(posedge clk);
      #1;
      c++;
    end
    checkOutput("drain_pending", 64'(exp_q.size()), 64'd0);
    checkOutput("drain_out_valid", 64'(bus.out_valid), 64'd0);
  endtask

  task automatic doReset();
    rst = 1'b1;
    #1;
    checkOutput("rst_in_ready", 64'(bus.in_ready), 64'd0);
    checkOutput("rst_wt_ready", 64'(bus.wt_ready), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int a = 0; a < NW; a++) mw[a] = 0;
    mch = 0;
    #1;
    checkOutput("post_rst_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("post_rst_ch_idx", 64'(bus.ch_idx), 64'd0);
    checkOutput("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
    checkOutput("post_rst_wt_ready", 64'(bus.wt_ready), 64'd1);
    for (int i = 0; i < N; i++) checkOutput("post_rst_out_sum", 64'(bus.out_sum[i]), 64'd0);
  endtask

  // Monitor: every handshake on the output port retires one scoreboard entry.
  initial begin
    vec_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_output: got out_valid=1 expected no pending group");
        end else begin
          e = exp_q.pop_front();
          for (int i = 0; i < N; i++)
            checkOutput($sformatf("out_sum[%0d]", i), 64'(bus.out_sum[i]), 64'(e[i]));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no completion expected $finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c;
    bus.signed_mode = 1'b0;
    bus.wt_we       = 1'b0;
    bus.wt_addr     = '0;
    bus.wt_data     = '0;
    bus.in_valid    = 1'b0;
    bus.in_pix      = '0;
    bus.out_ready   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    doReset();

    $display("[TB] unsigned accumulation with latency check");
    loadWeights(0, 0);
    for (int p = 1; p <= 4; p++) applyStimulus(p, 1'b0);
    checkOutput("latency_edge0", 64'(bus.out_valid), 64'd0);
    @(posedge clk);
    #1;
    checkOutput("latency_edge1", 64'(bus.out_valid), 64'd1);
    drain();

    $display("[TB] signed versus unsigned");
    loadWeights(1, 2);
    repeat (4) applyStimulus(255, 1'b1);
    repeat (4) applyStimulus(255, 1'b0);
    drain();

    $display("[TB] backpressure");
    loadWeights(2, 0);
    bus.out_ready = 1'b0;
    repeat (4) applyStimulus($urandom_range(0, 255), 1'b0);
    fork
      begin
        repeat (4) applyStimulus($urandom_range(0, 255), 1'b1);
      end
      begin
        c = 0;
        while (!bus.out_valid && c < 20) begin
          @(posedge clk);
          #1;
          c++;
        end
        repeat (6) begin
          @(negedge clk);
          checkOutput("stall_in_ready", 64'(bus.in_ready), 64'd0);
          checkOutput("stall_out_valid", 64'(bus.out_valid), 64'd1);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();

    $display("[TB] weight write gating");
    loadWeights(1, 1);
    applyStimulus(1, 1'b0);
    applyStimulus(1, 1'b0);
    bus.wt_we   = 1'b1;
    bus.wt_addr = AW'(2 * N);
    bus.wt_data = 8'd7;
    @(negedge clk);
    checkOutput("wt_ready_midgroup", 64'(bus.wt_ready), 64'd0);
    @(posedge clk);
    #1;
    bus.wt_we = 1'b0;
    applyStimulus(1, 1'b0);
    applyStimulus(1, 1'b0);
    drain();
    checkOutput("wt_ready_idle", 64'(bus.wt_ready), 64'd1);
    writeWeight(2 * N, 7);
    repeat (4) applyStimulus(1, 1'b0);
    drain();

    $display("[TB] reset mid-group");
    applyStimulus(9, 1'b0);
    applyStimulus(9, 1'b0);
    doReset();
    repeat (4) applyStimulus($urandom_range(0, 255), 1'b0);
    drain();
    loadWeights(1, 1);
    repeat (4) applyStimulus(5, 1'b0);
    drain();

    $display("[TB] mode change mid-group");
    loadWeights(1, 2);
    applyStimulus(255, 1'b0);
    repeat (3) applyStimulus(255, 1'b1);
    drain();

    $display("[TB] out-of-range weight address and randomised traffic");
    loadWeights(2, 0);
    writeWeight(40, 99);
    rand_done = 1'b0;
    fork
      begin
        for (int g = 0; g < 30; g++) begin
          for (int b = 0; b < CH; b++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            applyStimulus($urandom_range(0, 255), 1'($urandom_range(0, 1)));
          end
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();
    checkOutput("final_ch_idx", 64'(bus.ch_idx), 64'(mch));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
